// File: rtl/store_narrow_if.sv
// store_narrow_if: request and memory-write handshake bundle; slave is the store unit, master drives it
interface store_narrow_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_last;
  logic        mem_ovf;
  modport master (
    output req_valid, req_data, req_addr, req_size, req_signed, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_byte_en, mem_last, mem_ovf
  );
  modport slave (
    input  req_valid, req_data, req_addr, req_size, req_signed, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_byte_en, mem_last, mem_ovf
  );
endinterface

// File: rtl/store_narrow.sv
// store_narrow: narrows a register value to byte/half/word, places it on byte lanes, flags overflow and faults (STORE_NARROW_SPLIT_EN enables misaligned split stores)
module store_narrow #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  store_narrow_if.slave    bus,
  output logic             fault_valid,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] fault_count
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  state_t      state, nxt;
  logic        rdy_q, ovf_q, split_q;
  logic [29:0] base_q;
  logic [31:0] wd0_q, wd1_q;
  logic [3:0]  en0_q, en1_q;
  logic [1:0]  k;
  logic        is_b, is_h, is_w, mis, bad, ovf, acc, b1;
  logic [31:0] val, wd0;
  logic [3:0]  m;
  logic [63:0] sh;
  logic [7:0]  em;
  // Lane placement works on a 64-bit window: the low half is beat 0, the high half spills into beat 1.
  always_comb begin
    k    = bus.req_addr[1:0];
    is_b = bus.req_size == 2'b00;
    is_h = bus.req_size == 2'b01;
    is_w = bus.req_size == 2'b10;
    bad  = bus.req_size == 2'b11;
    val  = is_h ? {16'b0, bus.req_data[15:0]} : bus.req_data;
    m    = is_b ? 4'b0001 : is_h ? 4'b0011 : 4'b1111;
    sh   = {32'b0, val} << {k, 3'b000};
    em   = {4'b0, m} << k;
    wd0  = is_b ? {4{bus.req_data[7:0]}} : (is_h && !k[0]) ? {2{bus.req_data[15:0]}} : sh[31:0];
`ifdef STORE_NARROW_SPLIT_EN
    mis  = 1'b0;
`else
    mis  = (is_h && k[0]) || (is_w && k != 2'b00);
`endif
    ovf  = is_b ? (bus.req_signed ? !(&bus.req_data[31:7] || ~|bus.req_data[31:7]) : |bus.req_data[31:8]) :
           is_h ? (bus.req_signed ? !(&bus.req_data[31:15] || ~|bus.req_data[31:15]) : |bus.req_data[31:16]) : 1'b0;
    acc  = bus.req_valid && rdy_q && state == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? ((acc && !bad && !mis) ? BEAT0 : IDLE) :
          !bus.mem_ready ? state :
          (state == BEAT0 && split_q) ? BEAT1 : IDLE;
    b1              = state == BEAT1;
    bus.req_ready   = rdy_q && state == IDLE;
    bus.mem_valid   = state != IDLE;
    bus.mem_addr    = {b1 ? base_q + 30'd1 : base_q, 2'b00};
    bus.mem_wdata   = b1 ? wd1_q : wd0_q;
    bus.mem_byte_en = b1 ? en1_q : en0_q;
    bus.mem_last    = b1 || (state == BEAT0 && !split_q);
    bus.mem_ovf     = bus.mem_valid && ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      base_q      <= '0;
      wd0_q       <= '0;
      wd1_q       <= '0;
      en0_q       <= '0;
      en1_q       <= '0;
      ovf_q       <= 1'b0;
      split_q     <= 1'b0;
      fault_valid <= 1'b0;
      fault_code  <= '0;
      fault_count <= '0;
    end else begin
      rdy_q       <= 1'b1;
      fault_valid <= acc && (bad || mis);
      if (acc && !bad && !mis) begin
        base_q  <= bus.req_addr[31:2];
        wd0_q   <= wd0;
        wd1_q   <= sh[63:32];
        en0_q   <= em[3:0];
        en1_q   <= em[7:4];
        ovf_q   <= ovf;
        split_q <= |em[7:4];
      end
      if (acc && (bad || mis)) begin
        fault_code  <= bad ? 2'b10 : 2'b01;
        fault_count <= &fault_count ? fault_count : fault_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_store_narrow.sv
// tb_store_narrow: randomized store requests checked against a byte-lane reference model
module tb_store_narrow;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fault_valid;
  logic [1:0] fault_code;
  logic [7:0] fault_count;
  int         tests = 0;
  int         fails = 0;
  int         cnt_exp = 0;
  logic        m_fault, m_ovf;
  logic [1:0]  m_code;
  int          m_nb;
  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [31:0] m_mask [2];
  logic [3:0]  m_en [2];
  store_narrow_if bus();
  store_narrow #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fault_valid(fault_valid), .fault_code(fault_code), .fault_count(fault_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Each source byte i goes to absolute address a+i; the word it lands in decides the beat.
  task automatic model(input logic [31:0] d, input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int n;
    longint v, lim;
    logic [31:0] ab;
    int b;
    n = 1 << sz;
    m_fault = 1'b0;
    m_code = 2'b00;
    if (sz == 2'b11) begin
      m_fault = 1'b1;
      m_code = 2'b10;
      return;
    end
`ifndef STORE_NARROW_SPLIT_EN
    if ((a & (n - 1)) != 0) begin
      m_fault = 1'b1;
      m_code = 2'b01;
      return;
    end
`endif
    for (int i = 0; i < 2; i++) begin
      m_en[i] = 4'b0;
      m_data[i] = 32'b0;
      m_addr[i] = ((a >> 2) + i) << 2;
    end
    for (int i = 0; i < n; i++) begin
      ab = a + i;
      b = ((ab >> 2) != (a >> 2)) ? 1 : 0;
      m_en[b][ab[1:0]] = 1'b1;
      m_data[b][ab[1:0]*8 +: 8] = d[i*8 +: 8];
    end
    m_nb = (m_en[1] != 4'b0) ? 2 : 1;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) m_mask[i][j*8 +: 8] = {8{m_en[i][j]}};
    if (sz == 2'b00) begin
      m_data[0] = {4{d[7:0]}};
      m_mask[0] = 32'hFFFF_FFFF;
    end else if (sz == 2'b01 && !a[0]) begin
      m_data[0] = {2{d[15:0]}};
      m_mask[0] = 32'hFFFF_FFFF;
    end else if (sz == 2'b10) begin
      m_mask[0] = 32'hFFFF_FFFF;
      m_mask[1] = 32'hFFFF_FFFF;
    end
    if (sz == 2'b10) m_ovf = 1'b0;
    else if (sg) begin
      v = longint'($signed(d));
      lim = longint'(1) << (8 * n - 1);
      m_ovf = (v < -lim) || (v >= lim);
    end else begin
      v = longint'(d);
      m_ovf = v >= (longint'(1) << (8 * n));
    end
  endtask
  task automatic beat_chk(input int b);
    check("mem_valid", bus.mem_valid, 1);
    check("mem_addr", bus.mem_addr, m_addr[b]);
    check("mem_byte_en", bus.mem_byte_en, m_en[b]);
    check("mem_wdata", bus.mem_wdata & m_mask[b], m_data[b] & m_mask[b]);
    check("mem_last", bus.mem_last, (b == m_nb - 1) ? 1 : 0);
    check("mem_ovf", bus.mem_ovf, m_ovf);
    check("req_ready busy", bus.req_ready, 0);
  endtask
  // stall < 0 picks a random stall of 0..2 cycles per beat.
  task automatic issue(input logic [31:0] d, input logic [31:0] a, input logic [1:0] sz, input logic sg, input int stall);
    int w, s;
    model(d, a, sz, sg);
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("req_ready wait", bus.req_ready, 1);
    bus.req_data = d;
    bus.req_addr = a;
    bus.req_size = sz;
    bus.req_signed = sg;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_data = $urandom;
    bus.req_addr = $urandom;
    if (m_fault) begin
      cnt_exp = (cnt_exp == 255) ? 255 : cnt_exp + 1;
      check("fault_valid", fault_valid, 1);
      check("fault_code", fault_code, m_code);
      check("fault_count", fault_count, cnt_exp);
      check("mem_valid on fault", bus.mem_valid, 0);
      @(posedge clk); #1;
      check("fault pulse end", fault_valid, 0);
      check("mem_valid after fault", bus.mem_valid, 0);
    end else begin
      check("fault_valid quiet", fault_valid, 0);
      for (int b = 0; b < m_nb; b++) begin
        s = (stall < 0) ? $urandom_range(2, 0) : stall;
        for (int j = 0; j <= s; j++) begin
          bus.mem_ready = (j == s);
          beat_chk(b);
          @(posedge clk); #1;
        end
      end
      bus.mem_ready = 1'b0;
      check("mem_valid after", bus.mem_valid, 0);
      check("req_ready after", bus.req_ready, 1);
    end
  endtask
  initial begin
    logic [31:0] d, a;
    logic [1:0]  sz;
    bus.req_valid = 1'b0;
    bus.req_data = '0;
    bus.req_addr = '0;
    bus.req_size = '0;
    bus.req_signed = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("rst req_ready", bus.req_ready, 0);
    check("rst mem_valid", bus.mem_valid, 0);
    check("rst fault_valid", fault_valid, 0);
    check("rst fault_count", fault_count, 0);
    check("rst mem_last", bus.mem_last, 0);
    check("rst mem_ovf", bus.mem_ovf, 0);
    @(posedge clk); #1;
    check("rst held req_ready", bus.req_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post rst req_ready", bus.req_ready, 1);
    issue(32'hFFFF_FF80, 32'h0000_1002, 2'b00, 1'b1, 0);
    issue(32'h0000_0180, 32'h0000_1001, 2'b00, 1'b0, 1);
    issue(32'h0000_0180, 32'h0000_1003, 2'b00, 1'b1, 0);
    issue(32'h0000_1234, 32'h0000_2002, 2'b01, 1'b0, 3);
    issue(32'h0000_1234, 32'h0000_4000, 2'b11, 1'b0, 0);
    issue(32'hAABB_CCDD, 32'h0000_3001, 2'b10, 1'b0, 0);
    issue(32'hAABB_CCDD, 32'h0000_5003, 2'b01, 1'b1, 1);
    issue(32'h1234_5678, 32'hFFFF_FFFE, 2'b10, 1'b0, 1);
    issue(32'hFFFF_8000, 32'h0000_6002, 2'b01, 1'b1, 0);
    issue(32'h0000_8000, 32'h0000_6000, 2'b01, 1'b1, 0);
    // reset while a beat is stalled
    bus.req_data = 32'h0000_0055;
    bus.req_addr = 32'h0000_7000;
    bus.req_size = 2'b00;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("pre-reset mem_valid", bus.mem_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst mem_valid", bus.mem_valid, 0);
    check("async rst req_ready", bus.req_ready, 0);
    check("async rst fault_count", fault_count, 0);
    cnt_exp = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no beat after reset", bus.mem_valid, 0);
    end
    bus.mem_ready = 1'b0;
    check("ready after reset", bus.req_ready, 1);
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(3, 0));
      if ($urandom_range(9, 0) == 0) sz = 2'b11;
      else if (sz == 2'b11) sz = 2'b10;
      a = $urandom;
      if ($urandom_range(7, 0) == 0) a = 32'hFFFF_FFFC | (a & 32'h3);
      case ($urandom_range(3, 0))
        0: d = $urandom;
        1: d = $urandom_range(255, 0);
        2: d = 32'hFFFF_FF00 | $urandom_range(255, 0);
        default: d = $urandom_range(65535, 0) | (($urandom_range(1, 0) == 1) ? 32'hFFFF_0000 : 32'h0);
      endcase
      issue(d, a, sz, 1'($urandom_range(1, 0)), -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/store_narrow.md
Name: store_narrow

Overview:
- Store-side data path unit. It is the inverse of the load-side sign extender.
- Takes a 32-bit register value plus an access size, narrows it to a byte, halfword or word, and places it on the correct little-endian byte lanes with byte enables.
- Checks whether the value fits the narrow width (signed or unsigned overflow) and flags alignment faults.
- Sits between the execute stage and the data-memory write port. Uses a valid/ready handshake on both sides.

Parameters:
- CNT_W, 8, width of the saturating fault counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rstN  input  1  asynchronous, active-low reset
- reqValid  input  1  store request present
- reqReady  output  1  unit can accept a request
- reqData  input  32  register value to store
- reqAddr  input  32  byte address
- reqSize  input  2  00 byte, 01 half, 10 word, 11 illegal
- reqSigned  input  1  1: signed overflow check; 0: unsigned overflow check
- memValid  output  1  write beat valid
- memReady  input  1  memory accepts the beat
- memAddr  output  32  word-aligned address (bits [1:0] = 00)
- memWData  output  32  lane-placed write data
- memByteEn  output  4  byte-lane enables
- memLast  output  1  final beat of this request
- memOvf  output  1  value did not fit the narrow width (valid with memValid)
- faultValid  output  1  one-cycle pulse: request dropped
- faultCode  output  2  01 misaligned, 10 illegal size (valid with faultValid)
- faultCount  output  CNT_W  saturating count of dropped requests

Behaviour:
- Reset values (rstN low, asynchronous): reqReady 0 while reset is asserted and 1 from the first cycle after release. All other outputs are 0, and state is IDLE.
- States: IDLE, BEAT0, BEAT1. reqReady = (state == IDLE).
- Acceptance: in IDLE with reqValid=1 the request is captured. The next cycle drives BEAT0 with memValid=1, giving 1-cycle latency. There is no combinational path from req* to mem*.
- Illegal size or disallowed misalignment: nothing is issued. faultValid pulses the next cycle with faultCode set, faultCount increments (saturating at all-ones), and state stays IDLE.
- Beat outputs stay stable while memValid=1 and memReady=0.
  - BEAT0 with memReady: go to BEAT1 if the request was split, otherwise IDLE.
  - BEAT1 with memReady: go to IDLE.
- Lane placement, with k = reqAddr[1:0] and memAddr = {reqAddr[31:2], 2'b00}:
  - Byte: memWData = {4{reqData[7:0]}}, memByteEn = 0001 << k.
  - Half at k=0 or k=2: memWData = {2{reqData[15:0]}}, memByteEn = 0011 << k.
  - Word at k=0: memWData = reqData, memByteEn = 1111.
- Overflow check:
  - Signed byte: reqData[31:7] must be all equal. Signed half: reqData[31:15] must be all equal.
  - Unsigned byte: reqData[31:8] must be 0. Unsigned half: reqData[31:16] must be 0.
  - Word never overflows.
  - memOvf is registered with the request and is the same on every beat. The store still proceeds, truncated.
- memLast = 1 on the final beat only.
- Reset mid-operation discards any pending beat and returns to IDLE. Nothing completes after reset.
- Back-to-back: a new request is accepted in the cycle after the final beat handshakes, because reqReady rises when state returns to IDLE.

Optional Feature:
- Macro: STORE_NARROW_SPLIT_EN.
- Defined:
  - Half at k=1: single beat, memByteEn = 0110.
  - Half at k=3: two beats. Beat 0 has memByteEn 1000 with data[7:0] on lane 3. Beat 1 has memAddr+4, memByteEn 0001, data[15:8] on lane 0.
  - Word at k≠0: two beats.
    - Beat 0: memByteEn = (1111 << k) & 1111, memWData = reqData << 8k.
    - Beat 1: memAddr+4, memByteEn = 1111 >> (4-k), memWData = reqData >> 8(4-k).
  - Address wrap at 0xFFFFFFFC+4 goes to 0.
- Not defined: any half at odd k or any word at k≠0 is a misaligned fault (faultCode 01), and the BEAT1 state is unreachable.

Test Plan:
- Byte store, reqData=0xFFFFFF80, reqAddr=0x1002, signed -> one cycle later: memWData=0x80808080, memByteEn=0100, memAddr=0x1000, memOvf=0, memLast=1.
- Byte store, reqData=0x00000180, unsigned, then signed -> memOvf=1 in both cases, memByteEn still issued.
- Half store, reqData=0x00001234, reqAddr=0x2002, memReady held low for 3 cycles -> memWData=0x12341234 and memByteEn=1100 stay stable for the whole stall, and reqReady=0 throughout.
- reqSize=11, then word at reqAddr=0x3001 (macro off) -> two faultValid pulses with codes 10 then 01, faultCount=2, memValid never asserted.
- Macro on: word reqData=0xAABBCCDD at 0x3001 -> beat 0: addr 0x3000, en 1110, data 0xBBCCDD00. Beat 1: addr 0x3004, en 0001, data 0x000000AA, memLast=1.
- rstN pulsed low during a stalled BEAT0 -> memValid=0 immediately, and no beat appears after release until a new request arrives.
